// File: rtl/split_mem_dm.sv
// split_mem_dm: stopwatch display manager with a circular multi-lap split memory.
// Shows the live time, the last split (blinking) or any stored split (review),
// and drives one {en, bcd[3:0], dp} word per digit to the seven-segment driver.
// Optional build macro SPLIT_LZB_EN enables leading-zero blanking of the display.
module split_mem_dm #(
   parameter int                DIGITS       = 8,
   parameter int                DEPTH        = 4,
   parameter int                BLINK_CYCLES = 50000000,
   parameter logic [DIGITS-1:0] DP_MASK      = DIGITS'(8'b01010100)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [DIGITS*4-1:0]        live_bcd,
   input  logic                       split_p,
   input  logic                       resume_p,
   input  logic                       browse_p,
   input  logic                       clear_p,
   output logic [DIGITS*6-1:0]        seg_data,
   output logic [1:0]                 mode,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic [$clog2(DEPTH)-1:0]   view_idx,
   output logic                       full
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

   localparam logic [1:0]    ST_LIVE   = 2'd0;
   localparam logic [1:0]    ST_HOLD   = 2'd1;
   localparam logic [1:0]    ST_REVIEW = 2'd2;

   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
   localparam logic [PW-1:0] PTR_ONE   = PW'(1);
   localparam logic [BW-1:0] BLINK_ONE = BW'(1);
   localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_CYCLES - 1);

   logic [1:0]          state_q,  state_d;
   logic [CW-1:0]       count_q,  count_d;
   logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]       view_q,   view_d;
   logic                light_q,  light_d;
   logic [BW-1:0]       blink_q,  blink_d;
   logic [DIGITS*4-1:0] mem_q [DEPTH];
   logic                mem_we_s;
   logic [PW-1:0]       oldest_s;
   logic [PW-1:0]       newest_s;
   logic [DIGITS*4-1:0] src_s;
   logic [3:0]          digit_s;
   logic                en_s;
   logic                dp_s;
`ifdef SPLIT_LZB_EN
   logic                blank_s;
`endif

   // With a full memory count[PW-1:0] is zero, so oldest collapses to wr_ptr.
   assign oldest_s = wr_ptr_q - count_q[PW-1:0];
   assign newest_s = wr_ptr_q - PTR_ONE;

   // Next-state logic: event priority clear > resume > split > browse, else blink.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      view_d   = view_q;
      light_d  = light_q;
      blink_d  = blink_q;
      mem_we_s = 1'b0;
      if (clear_p) begin
         state_d  = ST_LIVE;
         count_d  = '0;
         wr_ptr_d = '0;
         view_d   = '0;
         light_d  = 1'b1;
         blink_d  = '0;
      end else if (resume_p) begin
         // Resume in LIVE is a no-op; it still swallows lower-priority pulses.
         state_d = ST_LIVE;
         light_d = 1'b1;
         blink_d = '0;
      end else if (split_p) begin
         mem_we_s = 1'b1;
         view_d   = wr_ptr_q;
         wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (count_q == CNT_FULL) begin
            count_d = count_q;
         end else begin
            count_d = count_q + CNT_ONE;
         end
         state_d = ST_HOLD;
         light_d = 1'b1;
         blink_d = '0;
      end else if (browse_p && (count_q != '0)) begin
         if ((state_q == ST_REVIEW) && (view_q != newest_s)) begin
            view_d = view_q + PTR_ONE;
         end else begin
            view_d = oldest_s;
         end
         state_d = ST_REVIEW;
         light_d = 1'b1;
         blink_d = '0;
      end else if (state_q == ST_HOLD) begin
         if (blink_q == BLINK_MAX) begin
            blink_d = '0;
            light_d = ~light_q;
         end else begin
            blink_d = blink_q + BLINK_ONE;
         end
      end else begin
         light_d = 1'b1;
         blink_d = '0;
      end
   end

   // Control state registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_LIVE;
         count_q  <= '0;
         wr_ptr_q <= '0;
         view_q   <= '0;
         light_q  <= 1'b1;
         blink_q  <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         view_q   <= view_d;
         light_q  <= light_d;
         blink_q  <= blink_d;
      end
   end

   // Split memory: captures the live time at the write pointer on a split.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            mem_q[k] <= '0;
         end
      end else if (mem_we_s) begin
         mem_q[wr_ptr_q] <= live_bcd;
      end
   end

   // Display formatting: select source, apply light, optional blanking and dp pattern.
   always_comb begin
      seg_data = '0;
      digit_s  = 4'h0;
      en_s     = 1'b0;
      dp_s     = 1'b0;
`ifdef SPLIT_LZB_EN
      blank_s  = 1'b1;
`endif
      if (state_q == ST_LIVE) begin
         src_s = live_bcd;
      end else begin
         src_s = mem_q[view_q];
      end
      for (int i = DIGITS - 1; i >= 0; i--) begin
         digit_s = src_s[4*i +: 4];
         en_s    = light_q;
`ifdef SPLIT_LZB_EN
         // Blank leading zeros from the top; digit 0 always stays lit.
         if ((i != 0) && blank_s && (digit_s == 4'h0)) begin
            en_s = 1'b0;
         end else begin
            blank_s = 1'b0;
         end
`endif
         // Top-digit dp doubles as the review-mode marker.
         if ((state_q == ST_REVIEW) && (i == DIGITS - 1)) begin
            dp_s = 1'b1;
         end else begin
            dp_s = DP_MASK[i];
         end
         seg_data[6*i +: 6] = {en_s, digit_s, dp_s};
      end
   end

   assign mode     = state_q;
   assign count    = count_q;
   assign view_idx = view_q;
   assign full     = (count_q == CNT_FULL);

endmodule

// File: tb/tb_split_mem_dm.sv
// tb_split_mem_dm: scoreboard bench for split_mem_dm (DIGITS=8, DEPTH=4, BLINK_CYCLES=4).
// Stimulus pushes expected display/status records; a negedge monitor pops and compares.
module tb_split_mem_dm;

   localparam logic [7:0] DPM = 8'b01010100;

   typedef struct {
      string      name;
      logic [47:0] seg;
      logic [1:0]  mode;
      logic [2:0]  count;
      logic        full;
      logic [1:0]  view;
      logic        chk_view;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [31:0] live_bcd;
   logic        split_p, resume_p, browse_p, clear_p;
   logic [47:0] seg_data;
   logic [1:0]  mode;
   logic [2:0]  count;
   logic [1:0]  view_idx;
   logic        full;

   exp_t exp_q[$];
   int   checks;
   int   errors;

   split_mem_dm #(
      .DIGITS      (8),
      .DEPTH       (4),
      .BLINK_CYCLES(4),
      .DP_MASK     (DPM)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .live_bcd(live_bcd),
      .split_p (split_p),
      .resume_p(resume_p),
      .browse_p(browse_p),
      .clear_p (clear_p),
      .seg_data(seg_data),
      .mode    (mode),
      .count   (count),
      .view_idx(view_idx),
      .full    (full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected display word for a given source value, light state and review marker.
   function automatic logic [47:0] exp_seg(input logic [31:0] bcd, input logic light,
                                           input logic review);
      logic [47:0] s;
      logic [7:0]  dpm;
      logic [3:0]  d;
      logic        en;
      logic        blank;
      dpm   = DPM;
      s     = '0;
      blank = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         d  = bcd[4*i +: 4];
         en = light;
`ifdef SPLIT_LZB_EN
         if ((i != 0) && blank && (d == 4'h0)) en = 1'b0;
         else blank = 1'b0;
`endif
         s[6*i +: 6] = {en, d, (dpm[i] | (review && (i == 7)))};
      end
      return s;
   endfunction

   task automatic expect_out(input string name, input logic [47:0] seg, input logic [1:0] md,
                             input logic [2:0] cnt, input logic fl, input logic [1:0] vw,
                             input logic cv);
      exp_t e;
      e.name = name; e.seg = seg; e.mode = md; e.count = cnt; e.full = fl;
      e.view = vw; e.chk_view = cv;
      exp_q.push_back(e);
      @(negedge clk);
      #1;
   endtask

   task automatic pulse(input logic c, input logic r, input logic s, input logic b);
      clear_p = c; resume_p = r; split_p = s; browse_p = b;
      @(posedge clk);
      #1;
      clear_p = 1'b0; resume_p = 1'b0; split_p = 1'b0; browse_p = 1'b0;
   endtask

   // Monitor: pop one expectation per falling edge and compare every field.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         checks++;
         if (seg_data !== e.seg) begin
            errors++;
            $display("FAIL %s seg_data got=%h exp=%h", e.name, seg_data, e.seg);
         end
         checks++;
         if (mode !== e.mode) begin
            errors++;
            $display("FAIL %s mode got=%0d exp=%0d", e.name, mode, e.mode);
         end
         checks++;
         if (count !== e.count) begin
            errors++;
            $display("FAIL %s count got=%0d exp=%0d", e.name, count, e.count);
         end
         checks++;
         if (full !== e.full) begin
            errors++;
            $display("FAIL %s full got=%0d exp=%0d", e.name, full, e.full);
         end
         if (e.chk_view) begin
            checks++;
            if (view_idx !== e.view) begin
               errors++;
               $display("FAIL %s view_idx got=%0d exp=%0d", e.name, view_idx, e.view);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] vals [5];
      logic [47:0] hand;
      vals[0] = 32'h11111111; vals[1] = 32'h22222222; vals[2] = 32'h33333333;
      vals[3] = 32'h44444444; vals[4] = 32'h55555555;
      checks = 0; errors = 0;
      rst = 1'b1; live_bcd = 32'h12345678;
      split_p = 1'b0; resume_p = 1'b0; browse_p = 1'b0; clear_p = 1'b0;
      #23 rst = 1'b0;
      @(negedge clk); #1;

      // Reset state: live view, digit 0 = {1,8,0}.
      hand = exp_seg(32'h12345678, 1'b1, 1'b0);
      expect_out("reset", hand, 2'd0, 3'd0, 1'b0, 2'd0, 1'b1);
      checks++;
      if (seg_data[5:0] !== 6'b1_1000_0) begin
         errors++;
         $display("FAIL reset_digit0 got=%b exp=%b", seg_data[5:0], 6'b110000);
      end

      // Split captures 1234; display holds it while live moves on, then blinks 4/4.
      live_bcd = 32'h00001234;
      pulse(1'b0, 1'b0, 1'b1, 1'b0);
      live_bcd = 32'h00009999;
      expect_out("hold_e0", exp_seg(32'h00001234, 1'b1, 1'b0), 2'd1, 3'd1, 1'b0, 2'd0, 1'b1);
      for (int k = 1; k <= 9; k++) begin
         expect_out($sformatf("blink_e%0d", k),
                    exp_seg(32'h00001234, ((k / 4) % 2) == 0, 1'b0), 2'd1, 3'd1, 1'b0, 2'd0, 1'b1);
      end

      // Clear empties memory and returns to live.
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      expect_out("clear", exp_seg(32'h00009999, 1'b1, 1'b0), 2'd0, 3'd0, 1'b0, 2'd0, 1'b1);

      // Five splits A..E: E overwrites A, memory saturates full.
      for (int k = 0; k < 5; k++) begin
         live_bcd = vals[k];
         pulse(1'b0, 1'b0, 1'b1, 1'b0);
         expect_out($sformatf("split_%0d", k), exp_seg(vals[k], 1'b1, 1'b0), 2'd1,
                    (k < 4) ? 3'(k + 1) : 3'd4, (k >= 3), 2'(k % 4), 1'b1);
      end

      // Review order B, C, D, E, B with marker and steady light.
      pulse(1'b0, 1'b0, 1'b0, 1'b1);
      expect_out("review_B", exp_seg(vals[1], 1'b1, 1'b1), 2'd2, 3'd4, 1'b1, 2'd1, 1'b1);
      expect_out("review_B_steady", exp_seg(vals[1], 1'b1, 1'b1), 2'd2, 3'd4, 1'b1, 2'd1, 1'b1);
      pulse(1'b0, 1'b0, 1'b0, 1'b1);
      expect_out("review_C", exp_seg(vals[2], 1'b1, 1'b1), 2'd2, 3'd4, 1'b1, 2'd2, 1'b1);
      pulse(1'b0, 1'b0, 1'b0, 1'b1);
      expect_out("review_D", exp_seg(vals[3], 1'b1, 1'b1), 2'd2, 3'd4, 1'b1, 2'd3, 1'b1);
      pulse(1'b0, 1'b0, 1'b0, 1'b1);
      expect_out("review_E", exp_seg(vals[4], 1'b1, 1'b1), 2'd2, 3'd4, 1'b1, 2'd0, 1'b1);
      for (int k = 0; k < 5; k++) begin
         expect_out("review_E_steady", exp_seg(vals[4], 1'b1, 1'b1), 2'd2, 3'd4, 1'b1, 2'd0, 1'b1);
      end
      pulse(1'b0, 1'b0, 1'b0, 1'b1);
      expect_out("review_wrap_B", exp_seg(vals[1], 1'b1, 1'b1), 2'd2, 3'd4, 1'b1, 2'd1, 1'b1);

      // Resume from review returns to live.
      live_bcd = 32'h87654321;
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      expect_out("resume_review", exp_seg(32'h87654321, 1'b1, 1'b0), 2'd0, 3'd4, 1'b1, 2'd0, 1'b0);

      // Clear beats split in the same cycle: nothing captured.
      pulse(1'b1, 1'b0, 1'b1, 1'b0);
      expect_out("clear_vs_split", exp_seg(32'h87654321, 1'b1, 1'b0), 2'd0, 3'd0, 1'b0, 2'd0, 1'b1);

      // Browse with empty memory is ignored.
      pulse(1'b0, 1'b0, 1'b0, 1'b1);
      expect_out("browse_empty", exp_seg(32'h87654321, 1'b1, 1'b0), 2'd0, 3'd0, 1'b0, 2'd0, 1'b1);

      // Split then resume: live view with light on.
      live_bcd = 32'h00000042;
      pulse(1'b0, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 4; k++) @(posedge clk);
      #1;
      expect_out("hold_dark", exp_seg(32'h00000042, 1'b0, 1'b0), 2'd1, 3'd1, 1'b0, 2'd0, 1'b1);
      live_bcd = 32'h00000777;
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      expect_out("resume_hold", exp_seg(32'h00000777, 1'b1, 1'b0), 2'd0, 3'd1, 1'b0, 2'd0, 1'b1);

      // Resume beats split in the same cycle (and resume in live is a no-op).
      pulse(1'b0, 1'b1, 1'b1, 1'b0);
      expect_out("resume_vs_split", exp_seg(32'h00000777, 1'b1, 1'b0), 2'd0, 3'd1, 1'b0, 2'd0, 1'b1);

      // Leading-zero blanking vectors (hand-computed for both builds).
      live_bcd = 32'h00000305;
`ifdef SPLIT_LZB_EN
      hand = {6'b000000, 6'b000001, 6'b000000, 6'b000001,
              6'b000000, 6'b100111, 6'b100000, 6'b101010};
`else
      hand = {6'b100000, 6'b100001, 6'b100000, 6'b100001,
              6'b100000, 6'b100111, 6'b100000, 6'b101010};
`endif
      expect_out("lzb_0305", hand, 2'd0, 3'd1, 1'b0, 2'd0, 1'b0);
      live_bcd = 32'h00000000;
`ifdef SPLIT_LZB_EN
      hand = {6'b000000, 6'b000001, 6'b000000, 6'b000001,
              6'b000000, 6'b000001, 6'b000000, 6'b100000};
`else
      hand = {6'b100000, 6'b100001, 6'b100000, 6'b100001,
              6'b100000, 6'b100001, 6'b100000, 6'b100000};
`endif
      expect_out("lzb_zero", hand, 2'd0, 3'd1, 1'b0, 2'd0, 1'b0);

      // Asynchronous reset mid-HOLD: asserted after a rising edge, checked before the next one.
      live_bcd = 32'h00005555;
      pulse(1'b0, 1'b0, 1'b1, 1'b0);
      @(posedge clk);
      #3 rst = 1'b1;
      exp_q.push_back('{"async_reset", exp_seg(32'h00005555, 1'b1, 1'b0), 2'd0, 3'd0, 1'b0, 2'd0, 1'b1});
      @(negedge clk);
      #1 rst = 1'b0;

      @(negedge clk); #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
